// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl
// Brief    : Fixed-priority interrupt controller with edge/level sources,
//            in-service nesting and a claim/complete register window.
// Revision : 1.0
// ============================================================================
module int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               cs,
    input  logic               rd,
    input  logic               wr,
    input  logic [1:0]         addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               data_oe,
    output logic               irq
);

    localparam logic [1:0] c_ADDR_PENDING = 2'd0;
    localparam logic [1:0] c_ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] c_ADDR_CLAIM   = 2'd2;
    localparam logic [1:0] c_ADDR_MODE    = 2'd3;

    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_s_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_inserv;
    logic               r_irq;

    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic [NUM_SRC-1:0] w_srv_nxt;
    logic [4:0]         w_best;
    logic               w_any;
    logic               w_rd_sel;
    logic               w_wr_sel;
    logic               w_claim;
    logic               w_complete;
    logic [4:0]         w_cmp_raw;
    logic [4:0]         w_cmp_id;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_eligible = r_pending & r_enable;
    assign w_rd_sel   = cs & rd;
    assign w_wr_sel   = cs & wr;
    assign w_unused   = &{1'b0, data_in};

    // A source requests only if no in-service bit sits at or above its priority
    always_comb begin
        logic v_blocked;
        v_blocked = 1'b0;
        w_req     = '0;
        w_best    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_inserv[i]) begin
                v_blocked = 1'b1;
            end
            w_req[i] = w_eligible[i] & ~v_blocked;
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_best = 5'(i);
            end
        end
    end

    assign w_any = |w_req;

    // Claim side effect is suppressed when a write shares the cycle
    assign w_claim    = w_rd_sel & ~wr & (addr == c_ADDR_CLAIM) & w_any;
    assign w_cmp_raw  = data_in[4:0];
    assign w_complete = w_wr_sel & (addr == c_ADDR_CLAIM) & (w_cmp_raw != 5'd0)
                        & (w_cmp_raw <= 5'(NUM_SRC));
    assign w_cmp_id   = w_cmp_raw - 5'd1;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic w_set;
        logic w_clr;
        logic w_srv_set;
        logic w_srv_clr;

        assign w_set     = r_sync2[gi] & ~r_s_d[gi];
        assign w_clr     = (w_claim && (w_best == 5'(gi)))
                           || (w_wr_sel && (addr == c_ADDR_PENDING) && data_in[gi]);
        assign w_srv_set = w_claim && (w_best == 5'(gi));
        assign w_srv_clr = w_complete && (w_cmp_id == 5'(gi));

        // Edge bits: set has priority over a same-cycle clear; level bits track s
        assign w_pend_nxt[gi] = r_mode[gi] ? (w_set | (r_pending[gi] & ~w_clr))
                                           : r_sync2[gi];
        assign w_srv_nxt[gi]  = w_srv_set | (r_inserv[gi] & ~w_srv_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_s_d     <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_mode    <= '0;
            r_inserv  <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_sync1   <= src;
            r_sync2   <= r_sync1;
            r_s_d     <= r_sync2;
            r_pending <= w_pend_nxt;
            r_inserv  <= w_srv_nxt;
            r_irq     <= w_any;
            if (w_wr_sel && (addr == c_ADDR_ENABLE)) begin
                r_enable <= data_in[NUM_SRC-1:0];
            end
            if (w_wr_sel && (addr == c_ADDR_MODE)) begin
                r_mode <= data_in[NUM_SRC-1:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (addr)
            c_ADDR_PENDING: w_rdata = 32'(r_pending);
            c_ADDR_ENABLE:  w_rdata = 32'(r_enable);
            c_ADDR_CLAIM:   w_rdata = w_any ? {27'd0, w_best + 5'd1} : 32'd0;
            c_ADDR_MODE:    w_rdata = 32'(r_mode);
            default:        w_rdata = '0;
        endcase
    end

    assign data_out = w_rd_sel ? w_rdata : 32'd0;
    assign data_oe  = w_rd_sel;
    assign irq      = r_irq;

endmodule
`default_nettype wire
